mldsa_axil_ctrl: RTL
====================

# mldsa_axil_ctrl

AXI4-Lite control/status slave for the ML-DSA core, replacing the single-register mode/start port. It exposes a small word-addressed register file with mode select, self-clearing start, busy/done/error status, interrupt enable and an optional cycle counter. It tracks each core operation from `start_pulse` to `core_done` and raises `irq` on completion.

## Interface
- `ADDR_W`, default 8: AXI address width; only bits [ADDR_W-1:2] are decoded.
- `DATA_W`, default 32: AXI data width; must be ≥ 16.
- `MODE_W`, default 2: width of `main_mode`.
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `AWADDR` in ADDR_W, `AWVALID` in 1, `AWREADY` out 1: write address channel.
- `WDATA` in DATA_W, `WSTRB` in DATA_W/8, `WVALID` in 1, `WREADY` out 1: write data channel.
- `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response channel.
- `ARADDR` in ADDR_W, `ARVALID` in 1, `ARREADY` out 1: read address channel.
- `RDATA` out DATA_W, `RRESP` out 2, `RVALID` out 1, `RREADY` in 1: read data channel.
- `main_mode` out MODE_W: latched operation mode to the core.
- `start_pulse` out 1: one-cycle start strobe to the core.
- `core_done` in 1: one-cycle completion strobe from the core.
- `irq` out 1: level interrupt, equal to DONE & IRQ_EN.

## Operation
- Register map:
  - 0x00 CTRL: bit0 START, write-1 only, always reads 0. MODE occupies [8+MODE_W-1:8], read/write.
  - 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-clear), bit2 ERR (sticky, write-1-clear).
  - 0x08 IRQ_EN: bit0 (RW).
  - 0x0C CYCLES: cycles of the last completed operation (RO).
- Writes take effect only in byte lanes with a set `WSTRB` bit. START lives in lane 0. MODE lives in lane 1.
- FSM states:
  - IDLE: a START write moves to BUSY. `start_pulse` is asserted for exactly one cycle, the cycle after the write commits. MODE is frozen from that point.
  - BUSY: `core_done` moves to IDLE and sets DONE.
- START written while BUSY: ignored, no pulse, ERR set, BRESP = SLVERR (2'b10).
- MODE write while BUSY: ignored, BRESP = SLVERR.
- Unmapped address: write discarded, read returns 0, response SLVERR.
- Otherwise responses are OKAY (2'b00).
- `core_done` in IDLE: ignored.

## Timing
- Reset values: all READY = 0, BVALID = RVALID = 0, BRESP = RRESP = 0, RDATA = 0, `main_mode` = 0, `start_pulse` = 0, `irq` = 0. FSM is IDLE and all registers are 0.
- `AWREADY` is high while the AW holding buffer is empty. `WREADY` is high while the W holding buffer is empty. AW and W may arrive in either order or in the same cycle.
- A write commits in the cycle after both buffers are full and BVALID is low. BVALID rises in the same cycle the write commits and holds until BREADY. The buffers free on the commit.
- `ARREADY` is high while RVALID is low. RVALID rises 1 cycle after the AR handshake. RDATA and RRESP are registered and stable until RREADY.
- A read and a write in flight together are independent. A read returns the pre-commit value if it samples in the same cycle as the commit.
- `core_done` in the same cycle as a DONE write-1-clear: set wins, DONE = 1.
- START commit in the same cycle as `core_done` (BUSY): rejected as busy, giving ERR = 1 and SLVERR.
- `resetn` deasserting mid-operation: FSM returns to IDLE and all channel state is dropped. No pulse is pending.

## Configuration
- `MLDSA_CYCLE_CNT_EN` defined:
  - A DATA_W counter clears on `start_pulse` and increments each BUSY cycle, saturating at all-ones.
  - It is copied to CYCLES on `core_done`.
- `MLDSA_CYCLE_CNT_EN` undefined: no counter is built. 0x0C reads 0 with OKAY.

## Structure
- Package `mldsa_axil_pkg` holds:
  - register offsets (CTRL/STATUS/IRQ_EN/CYCLES);
  - RESP_OKAY/RESP_SLVERR;
  - STATUS bit indices;
  - the FSM state enum (IDLE, BUSY).
- One sub-module is natural: `mldsa_op_tracker`. It holds the IDLE/BUSY FSM, start strobe, DONE/ERR set logic and the optional cycle counter. The top level keeps the AXI channels and the register decode.

## Test plan
- AW then W (2 cycles apart) to 0x00, WDATA = 0x0000_0201 → one BRESP OKAY. `main_mode` = 2'b10, one `start_pulse`, STATUS reads 0x1.
- START again while BUSY → BRESP SLVERR, no pulse, STATUS bit2 = 1. Write 0x4 to 0x04 → ERR cleared.
- Set IRQ_EN = 1, start, pulse `core_done` after 37 BUSY cycles → `irq` = 1, STATUS = 0x2, CYCLES = 37 (with EN). Write 0x2 to 0x04 → `irq` = 0.
- Read 0x10 → RDATA 0, RRESP SLVERR. Hold RREADY low 5 cycles → RVALID and RDATA stay stable.
- Same-cycle `core_done` and DONE clear → DONE remains 1. Same-cycle START commit and `core_done` → SLVERR.
- Assert `resetn` low mid-BUSY → all outputs at reset values. A START after release pulses normally.

Source files
------------

// File: rtl/mldsa_axil_pkg.sv
// Shared definitions for the ML-DSA AXI4-Lite control block.
// Holds register byte offsets, AXI response codes, STATUS bit positions,
// the register-select decode type and the operation-tracker FSM states.
package mldsa_axil_pkg;

  // Register byte offsets.
  localparam logic [7:0] OffsCtrl   = 8'h00;
  localparam logic [7:0] OffsStatus = 8'h04;
  localparam logic [7:0] OffsIrqEn  = 8'h08;
  localparam logic [7:0] OffsCycles = 8'h0C;

  // AXI response codes.
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // STATUS bit positions.
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;
  localparam int unsigned StatusErrBit  = 2;

  // CTRL field positions.
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlModeLsb  = 8;

  typedef enum logic [2:0] {
    SelCtrl,
    SelStatus,
    SelIrqEn,
    SelCycles,
    SelNone
  } reg_sel_e;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } op_state_e;

endpackage

// File: rtl/mldsa_axil_ctrl_if.sv
// AXI4-Lite bus bundle for the ML-DSA control block.
// master: drives AW/W/AR and BREADY/RREADY (the bus initiator).
// slave:  drives AWREADY/WREADY/ARREADY and the B and R channels.
interface mldsa_axil_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/mldsa_op_tracker.sv
// Tracks one ML-DSA core operation from start strobe to core completion.
// Optional feature macro: MLDSA_CYCLE_CNT_EN builds the busy-cycle counter.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   start_wr_i      committed START write (accepted in IDLE, flagged as error in BUSY)
//   core_done_i     one-cycle completion strobe from the core
//   done_clr_i      write-1-clear of DONE
//   err_clr_i       write-1-clear of ERR
//   busy_o, done_o, err_o   status bits
//   start_pulse_o   one-cycle start strobe to the core
//   cycles_o        busy-cycle count of the last completed operation
module mldsa_op_tracker
  import mldsa_axil_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_wr_i,
  input  logic              core_done_i,
  input  logic              done_clr_i,
  input  logic              err_clr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              start_pulse_o,
  output logic [DATA_W-1:0] cycles_o
);

  op_state_e state_q, state_d;
  logic      pulse_q, pulse_d;
  logic      done_q, done_d;
  logic      err_q, err_d;

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    // Clears are applied first so a same-cycle set wins.
    if (done_clr_i) done_d = 1'b0;
    if (err_clr_i)  err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_wr_i) begin
          state_d = StBusy;
          pulse_d = 1'b1;
        end
      end
      StBusy: begin
        // A START landing on the completion cycle is still rejected as busy.
        if (start_wr_i) err_d = 1'b1;
        if (core_done_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o        = (state_q == StBusy);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign start_pulse_o = pulse_q;

`ifdef MLDSA_CYCLE_CNT_EN
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] cycles_q, cycles_d;

  always_comb begin
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    if (state_q == StBusy) begin
      // The strobe cycle is itself busy: clear and count it in one step.
      if (pulse_q) begin
        cnt_d = DATA_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + DATA_W'(1);
      end
      if (core_done_i) cycles_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: rtl/mldsa_axil_ctrl.sv
// AXI4-Lite control/status slave for the ML-DSA core.
// Registers: 0x00 CTRL (START w1, MODE rw), 0x04 STATUS (BUSY ro, DONE/ERR w1c),
// 0x08 IRQ_EN, 0x0C CYCLES (ro; only counts when MLDSA_CYCLE_CNT_EN is defined).
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   axil          AXI4-Lite slave bundle
//   main_mode     latched operation mode to the core
//   start_pulse   one-cycle start strobe to the core
//   core_done     one-cycle completion strobe from the core
//   irq           level interrupt, DONE & IRQ_EN
module mldsa_axil_ctrl
  import mldsa_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MODE_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  mldsa_axil_if.slave       axil,
  output logic [MODE_W-1:0] main_mode,
  output logic              start_pulse,
  input  logic              core_done,
  output logic              irq
);

  localparam int unsigned StrbW = DATA_W / 8;

  function automatic reg_sel_e decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = addr & ~ADDR_W'(3);
    if (word == ADDR_W'(OffsCtrl))   return SelCtrl;
    if (word == ADDR_W'(OffsStatus)) return SelStatus;
    if (word == ADDR_W'(OffsIrqEn))  return SelIrqEn;
    if (word == ADDR_W'(OffsCycles)) return SelCycles;
    return SelNone;
  endfunction

  // Keeps READYs low during reset and for the first cycle after release.
  logic ready_en_q;

  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]  w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              irq_en_q, irq_en_d;

  logic              commit;
  reg_sel_e          wsel, rsel;
  logic              start_wr, done_clr, err_clr;
  logic              busy, done, err;
  logic [DATA_W-1:0] cycles;

  assign axil.AWREADY = ready_en_q & ~aw_full_q;
  assign axil.WREADY  = ready_en_q & ~w_full_q;
  assign axil.ARREADY = ready_en_q & ~rvalid_q;
  assign axil.BVALID  = bvalid_q;
  assign axil.BRESP   = bresp_q;
  assign axil.RVALID  = rvalid_q;
  assign axil.RDATA   = rdata_q;
  assign axil.RRESP   = rresp_q;

  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign wsel   = decode(aw_addr_q);
  assign rsel   = decode(axil.ARADDR);

  // Write path: AW/W holding buffers, commit, response.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mode_d    = mode_q;
    irq_en_d  = irq_en_q;
    start_wr  = 1'b0;
    done_clr  = 1'b0;
    err_clr   = 1'b0;

    if (axil.AWVALID && axil.AWREADY) begin
      aw_full_d = 1'b1;
      aw_addr_d = axil.AWADDR;
    end
    if (axil.WVALID && axil.WREADY) begin
      w_full_d = 1'b1;
      w_data_d = axil.WDATA;
      w_strb_d = axil.WSTRB;
    end
    if (bvalid_q && axil.BREADY) bvalid_d = 1'b0;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RespOkay;
      unique case (wsel)
        SelCtrl: begin
          if (w_strb_q[0] && w_data_q[CtrlStartBit]) begin
            start_wr = 1'b1;
            if (busy) bresp_d = RespSlverr;
          end
          if (w_strb_q[1]) begin
            if (busy) bresp_d = RespSlverr;
            else      mode_d  = w_data_q[CtrlModeLsb +: MODE_W];
          end
        end
        SelStatus: begin
          if (w_strb_q[0]) begin
            done_clr = w_data_q[StatusDoneBit];
            err_clr  = w_data_q[StatusErrBit];
          end
        end
        SelIrqEn: begin
          if (w_strb_q[0]) irq_en_d = w_data_q[0];
        end
        SelCycles: ;
        default: bresp_d = RespSlverr;
      endcase
    end
  end

  // Read path: sampled from the pre-commit register values.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && axil.RREADY) rvalid_d = 1'b0;
    if (axil.ARVALID && axil.ARREADY) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RespOkay;
      unique case (rsel)
        SelCtrl:   rdata_d[CtrlModeLsb +: MODE_W] = mode_q;
        SelStatus: begin
          rdata_d[StatusBusyBit] = busy;
          rdata_d[StatusDoneBit] = done;
          rdata_d[StatusErrBit]  = err;
        end
        SelIrqEn:  rdata_d[0] = irq_en_q;
        SelCycles: rdata_d = cycles;
        default:   rresp_d = RespSlverr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      mode_q     <= '0;
      irq_en_q   <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
    end
  end

  mldsa_op_tracker #(
    .DATA_W (DATA_W)
  ) u_tracker (
    .clk           (clk),
    .resetn        (resetn),
    .start_wr_i    (start_wr),
    .core_done_i   (core_done),
    .done_clr_i    (done_clr),
    .err_clr_i     (err_clr),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .start_pulse_o (start_pulse),
    .cycles_o      (cycles)
  );

  assign main_mode = mode_q;
  assign irq       = done & irq_en_q;

  // Only a few data bits and the low strobe lanes carry register fields.
  logic unused_wbits;
  assign unused_wbits = ^{w_data_q, w_strb_q};

endmodule
